// File: rtl/vga_pkg.sv
// Shared widths and the RGB332 -> RGB444 colour expansion used by the VGA code feeder.
package vga_pkg;

  localparam int CODE_W  = 24;
  localparam int COLOR_W = 12;
  localparam int CPU_W   = 16;

  // Replicate the top bits of each channel so full-scale RGB332 maps to full-scale RGB444.
  function automatic logic [COLOR_W-1:0] rgb332_to_444(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

// File: rtl/vga_code_fifo.sv
// Synchronous FIFO for CPU display words; full/empty come from the occupancy count.
module vga_code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/vga_code_feeder.sv
// Buffers CPU display words and advances the VGA two-colour code only at frame starts.
// VGA_FEEDER_HOLD_EN adds a hold counter keeping each code on screen for HOLD_FRAMES frames.
module vga_code_feeder
  import vga_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_FRAMES = 72
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CPU_W-1:0]        in_data,
  input  logic                    vsync,
  output logic [CODE_W-1:0]       code,
  output logic                    updated,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int LW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (HOLD_FRAMES < 1)) begin : g_bad_cfg
    $error("vga_code_feeder: DEPTH must be a power of two >= 2 and HOLD_FRAMES >= 1");
  end

  logic              vsync_d_q;
  logic              fs_s, push_s, pop_s, hold_ok_s;
  logic [CPU_W-1:0]  head_s;
  logic [CODE_W-1:0] code_q, code_d;
  logic              updated_q, updated_d;

  assign fs_s     = vsync_d_q & ~vsync;
  assign in_ready = (level != LW'(DEPTH));
  assign push_s   = in_valid & in_ready;
  // Pop decision uses the pre-push level, so a same-cycle push into an empty FIFO waits a frame.
  assign pop_s    = fs_s & hold_ok_s & (level != '0);

  vga_code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CPU_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (in_data),
    .head_o  (head_s),
    .level_o (level)
  );

`ifdef VGA_FEEDER_HOLD_EN
  localparam int HW = $clog2(HOLD_FRAMES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_ok_s = (hold_cnt_q == HOLD_MAX);

  // Counts frames since the last pop; saturates so an idle period leaves the next pop unblocked.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (pop_s) begin
      hold_cnt_d = '0;
    end else if (fs_s && (hold_cnt_q < HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= HOLD_MAX;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_ok_s = 1'b1;
`endif

  always_comb begin
    code_d    = code_q;
    updated_d = pop_s;
    if (pop_s) begin
      code_d = {rgb332_to_444(head_s[15:8]), rgb332_to_444(head_s[7:0])};
    end else begin
      code_d = code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_q <= 1'b1;
      code_q    <= '0;
      updated_q <= 1'b0;
    end else begin
      vsync_d_q <= vsync;
      code_q    <= code_d;
      updated_q <= updated_d;
    end
  end

  assign code    = code_q;
  assign updated = updated_q;

endmodule
